uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/uart_tx_sched.sv | 154 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and
// default launch-to-busy timeout.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_HOLD
  } state_e;

  localparam int START_TIMEOUT_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: searches upward from last_grant+1,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  output logic [IDXW-1:0]    grant,
  output logic               valid
);

  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester byte scheduler in front of a UART transmitter: round-robin
// grant per packet, registered launch/ack, start timeout and packet abort.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       uart_transmit,
  output logic [7:0]                 uart_tx_byte,
  input  logic                       uart_is_transmitting,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       tx_error
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int TW   = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(START_TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic [IDXW-1:0]    last_grant_q, last_grant_d;
  logic [7:0]         byte_q, byte_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               xmit_q, xmit_d;
  logic               err_q, err_d;
  logic [TW-1:0]      cnt_q, cnt_d;

  logic [7:0]         data_a [NUM_REQ];
  logic [IDXW-1:0]    arb_grant;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_a[i] = req_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= LAST_IDX;
      byte_q       <= 8'h00;
      last_q       <= 1'b0;
      ack_q        <= '0;
      xmit_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      ack_q        <= ack_d;
      xmit_q       <= xmit_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Launch strobe and ack are produced on the capture edge so they land
  // together in the LAUNCH cycle; req is never looked at during LAUNCH.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    byte_d       = byte_q;
    last_d       = last_q;
    ack_d        = '0;
    xmit_d       = 1'b0;
    err_d        = 1'b0;
    cnt_d        = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d          = arb_grant;
          byte_d           = data_a[arb_grant];
          last_d           = req_last[arb_grant];
          ack_d[arb_grant] = 1'b1;
          xmit_d           = 1'b1;
          state_d          = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = TIMER_LOAD;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (uart_is_transmitting) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == '0) begin
          err_d        = 1'b1;
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          if (last_q) begin
            last_grant_d = owner_q;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (req[owner_q]) begin
          byte_d         = data_a[owner_q];
          last_d         = req_last[owner_q];
          ack_d[owner_q] = 1'b1;
          xmit_d         = 1'b1;
          state_d        = ST_LAUNCH;
        end else begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack           = ack_q;
  assign uart_transmit = xmit_q;
  assign uart_tx_byte  = byte_q;
  assign owner         = owner_q;
  assign busy          = (state_q != ST_IDLE);
  assign tx_error      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requester queues, a simple UART busy model, a
// transaction-level reference model compared every cycle, plus directed checks.
`timescale 1ns/1ps
module tb_uart_tx_sched;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic           uart_transmit;
  logic [7:0]     uart_tx_byte;
  logic           uart_is_transmitting;
  logic [1:0]     owner;
  logic           busy, tx_error;

  uart_tx_sched #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting), .owner(owner), .busy(busy),
    .tx_error(tx_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- requester queues ----------------
  logic [8:0] rmem [N][16];
  int rhead [N];
  int rtail [N];

  task automatic push(input int i, input logic l, input logic [7:0] b);
    rmem[i][rtail[i] % 16] = {l, b};
    rtail[i]++;
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < N; i++) if (rhead[i] != rtail[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; end
    req = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; end
        req = '0; req_data = '0; req_last = '0;
      end else begin
        for (int i = 0; i < N; i++)
          if (ack[i] && rhead[i] != rtail[i]) rhead[i]++;
        for (int i = 0; i < N; i++) begin
          if (rhead[i] != rtail[i]) begin
            req[i]           = 1'b1;
            req_data[i*8+:8] = rmem[i][rhead[i] % 16][7:0];
            req_last[i]      = rmem[i][rhead[i] % 16][8];
          end else begin
            req[i]           = 1'b0;
            req_data[i*8+:8] = 8'h00;
            req_last[i]      = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- UART model ----------------
  // Busy rises two cycles after the launch strobe and stays high four cycles.
  bit uart_dead;
  int u_cnt;
  initial begin
    uart_is_transmitting = 1'b0;
    u_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        u_cnt = 0;
      end else if (uart_transmit && !uart_dead) begin
        u_cnt = 6;
      end else if (u_cnt > 0) begin
        u_cnt--;
      end
      uart_is_transmitting = (u_cnt >= 1 && u_cnt <= 4);
    end
  end

  // ---------------- reference model ----------------
  // Phases: 0 free, 1 strobe, 2 awaiting UART start, 3 UART busy, 4 between bytes.
  int         m_phase, m_owner, m_lastg, m_elapsed, pick, idx;
  logic [7:0] m_byte;
  logic       m_last;
  logic       e_xmit, e_err, e_busy;
  logic [N-1:0] e_ack;
  logic [7:0] e_byte;
  logic [1:0] e_owner;

  initial forever begin
    @(posedge clk or posedge rst);
    e_xmit = 1'b0; e_err = 1'b0; e_ack = '0;
    if (rst) begin
      m_phase = 0; m_owner = 0; m_lastg = N - 1; m_byte = 8'h00;
      m_last = 1'b0; m_elapsed = 0;
    end else begin
      case (m_phase)
        0: begin
          pick = -1;
          for (int k = 1; k <= N; k++) begin
            idx = (m_lastg + k) % N;
            if (pick < 0 && req[idx]) pick = idx;
          end
          if (pick >= 0) begin
            m_owner = pick; m_byte = req_data[pick*8+:8]; m_last = req_last[pick];
            e_xmit = 1'b1; e_ack[pick] = 1'b1; m_phase = 1;
          end
        end
        1: begin m_phase = 2; m_elapsed = 0; end
        2: begin
          if (uart_is_transmitting) m_phase = 3;
          else begin
            m_elapsed++;
            if (m_elapsed == TO) begin e_err = 1'b1; m_lastg = m_owner; m_phase = 0; end
          end
        end
        3: if (!uart_is_transmitting) begin
          if (m_last) begin m_lastg = m_owner; m_phase = 0; end
          else m_phase = 4;
        end
        4: begin
          if (req[m_owner]) begin
            m_byte = req_data[m_owner*8+:8]; m_last = req_last[m_owner];
            e_xmit = 1'b1; e_ack[m_owner] = 1'b1; m_phase = 1;
          end else begin
            m_lastg = m_owner; m_phase = 0;
          end
        end
        default: m_phase = 0;
      endcase
    end
    e_byte = m_byte; e_owner = 2'(m_owner); e_busy = (m_phase != 0);
  end

  // ---------------- compare + launch log ----------------
  logic [N-1:0] log_ack  [32];
  int           log_own  [32];
  logic [7:0]   log_byte [32];
  int           log_cyc  [32];
  int log_n, err_n, err_cyc;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      checks++;
      if (uart_transmit !== e_xmit || ack !== e_ack || tx_error !== e_err ||
          busy !== e_busy || owner !== e_owner || uart_tx_byte !== e_byte) begin
        failures++;
        $display("FAIL cycle%0d outputs: got xmit=%b ack=%b err=%b busy=%b owner=%0d byte=%h, need xmit=%b ack=%b err=%b busy=%b owner=%0d byte=%h",
                 cyc, uart_transmit, ack, tx_error, busy, owner, uart_tx_byte,
                 e_xmit, e_ack, e_err, e_busy, e_owner, e_byte);
      end
      if (uart_transmit && log_n < 32) begin
        log_ack[log_n] = ack; log_own[log_n] = int'(owner);
        log_byte[log_n] = uart_tx_byte; log_cyc[log_n] = cyc; log_n++;
      end
      if (tx_error) begin err_n++; err_cyc = cyc; end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, need %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    int ok;
    ok = 0;
    for (int c = 0; c < max_cyc && ok < 3; c++) begin
      @(negedge clk);
      if (!busy && q_empty() && !uart_is_transmitting) ok++; else ok = 0;
    end
    checks++;
    if (ok < 3) begin
      failures++;
      $display("FAIL %s: not idle after %0d cycles, busy=%b need 0", nm, max_cyc, busy);
    end
  endtask

  int fair_exp [5] = '{0, 1, 2, 3, 0};
  int wcnt;

  initial begin
    rst = 1'b1; uart_dead = 0; log_n = 0; err_n = 0; err_cyc = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_xmit",  uart_transmit, 0);
    chk("rst_ack",   ack, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_byte",  uart_tx_byte, 0);
    @(negedge clk);
    rst = 1'b0;

    // fairness: everyone requesting, single-byte packets
    log_n = 0;
    for (int i = 0; i < N; i++) for (int r = 0; r < 2; r++) push(i, 1'b1, 8'(8'h40 + i*16 + r));
    wait_idle(400, "fair_idle");
    chk("fair_count", log_n, 8);
    for (int k = 0; k < 5; k++) chk($sformatf("fair_own%0d", k), log_own[k], fair_exp[k]);
    chk("fair_ack0", log_ack[0], 4'b0001);

    // packet lock: requester 0 arrives mid-packet of requester 1
    log_n = 0;
    push(1, 1'b0, 8'h11); push(1, 1'b0, 8'h22); push(1, 1'b1, 8'h33);
    wcnt = 0;
    while (log_n < 1 && wcnt < 50) begin @(negedge clk); wcnt++; end
    chk("lock_started", log_n >= 1, 1);
    push(0, 1'b1, 8'h99);
    wait_idle(200, "lock_idle");
    chk("lock_count", log_n, 4);
    chk("lock_b0", log_byte[0], 8'h11);
    chk("lock_b1", log_byte[1], 8'h22);
    chk("lock_b2", log_byte[2], 8'h33);
    chk("lock_own2", log_own[2], 1);
    chk("lock_own3", log_own[3], 0);
    chk("lock_b3", log_byte[3], 8'h99);

    // single byte
    log_n = 0;
    push(2, 1'b1, 8'hA5);
    wait_idle(100, "single_idle");
    chk("single_count", log_n, 1);
    chk("single_byte", log_byte[0], 8'hA5);
    chk("single_owner", log_own[0], 2);
    chk("single_ack", log_ack[0], 4'b0100);

    // abort: requester 3 drops req between bytes
    log_n = 0; err_n = 0;
    push(3, 1'b0, 8'h3C);
    wait_idle(100, "abort_idle");
    push(1, 1'b1, 8'h01); push(0, 1'b1, 8'h00);
    wait_idle(200, "abort_next_idle");
    chk("abort_count", log_n, 3);
    chk("abort_own0", log_own[0], 3);
    chk("abort_own1", log_own[1], 0);
    chk("abort_own2", log_own[2], 1);
    chk("abort_noerr", err_n, 0);

    // timeout: UART never starts
    uart_dead = 1; log_n = 0; err_n = 0;
    push(1, 1'b1, 8'h77);
    wait_idle(100, "to_idle");
    uart_dead = 0;
    chk("to_err_count", err_n, 1);
    chk("to_err_delay", err_cyc - log_cyc[0], 9);

    // reset in the middle of a byte
    log_n = 0; err_n = 0;
    push(2, 1'b1, 8'h5A);
    wcnt = 0;
    while (!uart_is_transmitting && wcnt < 50) begin @(negedge clk); wcnt++; end
    chk("rmb_uart_busy", uart_is_transmitting, 1);
    @(negedge clk);
    chk("rmb_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rmb_busy",  busy, 0);
    chk("rmb_owner", owner, 0);
    chk("rmb_byte",  uart_tx_byte, 0);
    chk("rmb_xmit",  uart_transmit, 0);
    chk("rmb_err",   tx_error, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_n = 0;
    for (int i = 0; i < N; i++) push(i, 1'b1, 8'(8'hC0 + i));
    wait_idle(300, "rmb_idle");
    chk("rmb_first_owner", log_own[0], 0);
    chk("rmb_noerr", err_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
